ctrl_decode_seq: RTL and testbench

CTRL_DECODE_SEQ -- requirements
Module: ctrl_decode_seq

---
 rtl/ctrl_decode_seq.sv | 156 +++++++++++++++
 tb/tb_ctrl_decode_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_seq.sv
// ctrl_decode_seq: instruction decode and issue sequencer.
// Accepts one instruction word at a time and splits it into opcode, three
// register addresses and an immediate. It then holds those fields toward an
// execution unit until the unit takes them. Multi-cycle opcodes are tracked
// until the unit signals completion. The unit's status flags are captured
// when each operation retires.
module ctrl_decode_seq #(
  parameter int unsigned           ADDR_W       = 5,
  parameter int unsigned           IMM_W        = 8,
  parameter int unsigned           OPC_W        = 4,
  parameter int unsigned           INSTR_W      = 32,
  parameter logic [(1<<OPC_W)-1:0] MULTI_MASK   = '0,
  parameter logic [(1<<OPC_W)-1:0] ILLEGAL_MASK = '0,
  parameter int unsigned           FLAG_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode,
  output logic [ADDR_W-1:0]  addr1,
  output logic [ADDR_W-1:0]  addr2,
  output logic [ADDR_W-1:0]  addr3,
  output logic [IMM_W-1:0]   number,
  output logic               issue_valid,
  input  logic               eu_ready,
  input  logic               eu_done,
  input  logic [FLAG_W-1:0]  eu_flags,
  output logic [FLAG_W-1:0]  theflag,
  output logic               illegal,
  output logic               busy
);

  // The opcode sits at the top of the word and the fields pack from bit 0
  // upward. If those regions overlapped, the decode would be meaningless.
  if (INSTR_W < 3 * ADDR_W + IMM_W + OPC_W) begin : g_bad_width
    $error("ctrl_decode_seq: INSTR_W too small for the field layout");
  end

  localparam int unsigned NUM_LO = 3 * ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE,   // waiting for an instruction
    ST_ISSUE,  // fields presented to the execution unit
    ST_EXEC    // multi-cycle operation in flight
  } state_e;

  state_e              state_q;
  logic [OPC_W-1:0]    opcode_q;
  logic [ADDR_W-1:0]   addr1_q;
  logic [ADDR_W-1:0]   addr2_q;
  logic [ADDR_W-1:0]   addr3_q;
  logic [IMM_W-1:0]    number_q;
  logic                issue_valid_q;
  logic [FLAG_W-1:0]   theflag_q;
  logic                illegal_q;

  // Raw field slices of the incoming word. These only feed register inputs,
  // so no output ever depends combinationally on instr.
  logic [OPC_W-1:0]    instr_opc;
  logic [ADDR_W-1:0]   instr_a1;
  logic [ADDR_W-1:0]   instr_a2;
  logic [ADDR_W-1:0]   instr_a3;
  logic [IMM_W-1:0]    instr_num;

  assign instr_opc = instr[INSTR_W-1 -: OPC_W];
  assign instr_a1  = instr[ADDR_W-1:0];
  assign instr_a2  = instr[2*ADDR_W-1:ADDR_W];
  assign instr_a3  = instr[3*ADDR_W-1:2*ADDR_W];
  assign instr_num = instr[NUM_LO+IMM_W-1:NUM_LO];

  // The gap between the immediate and the opcode carries no information.
  // Folding the whole word marks those bits as intentionally ignored.
  logic unused_instr;
  assign unused_instr = ^instr;

  // Sequencer: accepts instructions, holds issue, and tracks multi-cycle ops.
  // NOTE: every register here is assigned with <= so all of them see the
  // pre-edge values; blocking assignments would let later lines observe
  // half-updated state and break the single-cycle handoffs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      opcode_q      <= '0;
      addr1_q       <= '0;
      addr2_q       <= '0;
      addr3_q       <= '0;
      number_q      <= '0;
      issue_valid_q <= 1'b0;
      theflag_q     <= '0;
      illegal_q     <= 1'b0;
    end else begin
      // illegal is a one-cycle pulse; it is cleared unless re-raised below.
      illegal_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // in_ready is high throughout IDLE outside reset, so in_valid alone
          // means an accept here.
          if (in_valid) begin
            if (ILLEGAL_MASK[instr_opc]) begin
              // Reject: flag it, leave the previous fields untouched.
              illegal_q <= 1'b1;
            end else begin
              opcode_q      <= instr_opc;
              addr1_q       <= instr_a1;
              addr2_q       <= instr_a2;
              addr3_q       <= instr_a3;
              number_q      <= instr_num;
              issue_valid_q <= 1'b1;
              state_q       <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // eu_done is not looked at here. A completion pulse coinciding with
          // the handoff belongs to nothing in flight and is dropped.
          if (eu_ready) begin
            issue_valid_q <= 1'b0;
            if (MULTI_MASK[opcode_q]) begin
              state_q <= ST_EXEC;
            end else begin
              theflag_q <= eu_flags;
              state_q   <= ST_IDLE;
            end
          end
        end
        ST_EXEC: begin
          if (eu_done) begin
            theflag_q <= eu_flags;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          issue_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Ready only in IDLE and forced low while reset is held. This lets an
  // instruction be taken on the very first cycle after release.
  assign in_ready    = rst_n && (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);

  assign opcode      = opcode_q;
  assign addr1       = addr1_q;
  assign addr2       = addr2_q;
  assign addr3       = addr3_q;
  assign number      = number_q;
  assign issue_valid = issue_valid_q;
  assign theflag     = theflag_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_ctrl_decode_seq.sv
// tb_ctrl_decode_seq: directed bench for ctrl_decode_seq.
// Instance A has default widths, opcode 3 as multi-cycle and opcode 15 as
// illegal. It is tracked every cycle by a transaction-level model.
// Instance B uses wide fields and is exercised with random instruction words.
module tb_ctrl_decode_seq;

  localparam logic [15:0] A_MULTI = 16'h0008;
  localparam logic [15:0] A_ILL   = 16'h8000;

  logic clk;
  logic rst_n;

  // ---------------- instance A (default widths) ----------------
  logic        a_in_valid;
  logic        a_in_ready;
  logic [31:0] a_instr;
  logic [3:0]  a_opcode;
  logic [4:0]  a_addr1, a_addr2, a_addr3;
  logic [7:0]  a_number;
  logic        a_issue_valid;
  logic        a_eu_ready;
  logic        a_eu_done;
  logic [3:0]  a_eu_flags;
  logic [3:0]  a_theflag;
  logic        a_illegal;
  logic        a_busy;

  ctrl_decode_seq #(
    .MULTI_MASK  (A_MULTI),
    .ILLEGAL_MASK(A_ILL)
  ) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .instr      (a_instr),
    .opcode     (a_opcode),
    .addr1      (a_addr1),
    .addr2      (a_addr2),
    .addr3      (a_addr3),
    .number     (a_number),
    .issue_valid(a_issue_valid),
    .eu_ready   (a_eu_ready),
    .eu_done    (a_eu_done),
    .eu_flags   (a_eu_flags),
    .theflag    (a_theflag),
    .illegal    (a_illegal),
    .busy       (a_busy)
  );

  // ---------------- instance B (wide fields) ----------------
  logic        b_in_valid;
  logic        b_in_ready;
  logic [39:0] b_instr;
  logic [4:0]  b_opcode;
  logic [5:0]  b_addr1, b_addr2, b_addr3;
  logic [9:0]  b_number;
  logic        b_issue_valid;
  logic        b_eu_ready;
  logic        b_eu_done;
  logic [3:0]  b_eu_flags;
  logic [3:0]  b_theflag;
  logic        b_illegal;
  logic        b_busy;

  ctrl_decode_seq #(
    .ADDR_W (6),
    .IMM_W  (10),
    .OPC_W  (5),
    .INSTR_W(40)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .instr      (b_instr),
    .opcode     (b_opcode),
    .addr1      (b_addr1),
    .addr2      (b_addr2),
    .addr3      (b_addr3),
    .number     (b_number),
    .issue_valid(b_issue_valid),
    .eu_ready   (b_eu_ready),
    .eu_done    (b_eu_done),
    .eu_flags   (b_eu_flags),
    .theflag    (b_theflag),
    .illegal    (b_illegal),
    .busy       (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction model of instance A ----------------
  // m_phase: 0 = no instruction held, 1 = offered to the unit, 2 = unit working.
  int          m_phase;
  logic [3:0]  m_op;
  logic [4:0]  m_a1, m_a2, m_a3;
  logic [7:0]  m_num;
  logic [3:0]  m_flag;
  logic        m_ill;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_op    <= '0;
      m_a1    <= '0;
      m_a2    <= '0;
      m_a3    <= '0;
      m_num   <= '0;
      m_flag  <= '0;
      m_ill   <= 1'b0;
    end else begin
      m_ill <= 1'b0;
      if (m_phase == 0 && a_in_valid) begin
        if (((A_ILL >> (a_instr >> 28)) & 16'd1) != 16'd0) begin
          m_ill <= 1'b1;
        end else begin
          m_op    <= 4'(a_instr >> 28);
          m_num   <= 8'(a_instr >> 15);
          m_a3    <= 5'(a_instr >> 10);
          m_a2    <= 5'(a_instr >> 5);
          m_a1    <= 5'(a_instr);
          m_phase <= 1;
        end
      end else if (m_phase == 1 && a_eu_ready) begin
        if (((A_MULTI >> m_op) & 16'd1) != 16'd0) begin
          m_phase <= 2;
        end else begin
          m_flag  <= a_eu_flags;
          m_phase <= 0;
        end
      end else if (m_phase == 2 && a_eu_done) begin
        m_flag  <= a_eu_flags;
        m_phase <= 0;
      end
    end
  end

  // Every-cycle comparison of instance A against the model, away from the edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready",    a_in_ready,    rst_n && (m_phase == 0));
      check("issue_valid", a_issue_valid, m_phase == 1);
      check("busy",        a_busy,        m_phase != 0);
      check("opcode",      a_opcode,      m_op);
      check("addr1",       a_addr1,       m_a1);
      check("addr2",       a_addr2,       m_a2);
      check("addr3",       a_addr3,       m_a3);
      check("number",      a_number,      m_num);
      check("theflag",     a_theflag,     m_flag);
      check("illegal",     a_illegal,     m_ill);
    end
  end

  // Watchdog: the stimulus never waits on the DUT, but bound the run anyway.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] tp_tab [8] = '{32'h2123_4567, 32'h4ABC_DEF0, 32'h5000_0001, 32'h6FFF_FFFF,
                              32'h0000_0000, 32'h7555_5555, 32'hE0F0_F0F0, 32'h8765_4321};

  initial begin
    int acc;
    rst_n      = 1'b0;
    a_in_valid = 1'b0;
    a_instr    = '0;
    a_eu_ready = 1'b0;
    a_eu_done  = 1'b0;
    a_eu_flags = '0;
    b_in_valid = 1'b0;
    b_instr    = '0;
    b_eu_ready = 1'b0;
    b_eu_done  = 1'b0;
    b_eu_flags = '0;

    // Reset state.
    tick();
    tick();
    check("rst in_ready",    a_in_ready,    1'b0);
    check("rst issue_valid", a_issue_valid, 1'b0);
    check("rst busy",        a_busy,        1'b0);
    check("rst theflag",     a_theflag,     4'h0);
    check("rst opcode",      a_opcode,      4'h0);
    check("rst illegal",     a_illegal,     1'b0);
    cmp_en = 1'b1;
    rst_n  = 1'b1;
    #1;
    check("release in_ready", a_in_ready, 1'b1);

    // Decode: op 1, number FE, addr3 10, addr2 12, addr1 03.
    a_instr    = 32'h107F_4243;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    a_instr    = 32'hFFFF_FFFF;
    check("dec opcode",      a_opcode,      4'h1);
    check("dec number",      a_number,      8'hFE);
    check("dec addr3",       a_addr3,       5'h10);
    check("dec addr2",       a_addr2,       5'h12);
    check("dec addr1",       a_addr1,       5'h03);
    check("dec issue_valid", a_issue_valid, 1'b1);
    check("dec in_ready",    a_in_ready,    1'b0);

    // Hold in ISSUE for 3 cycles; a stray eu_done there must not load flags.
    for (int i = 0; i < 3; i++) begin
      a_eu_done  = (i == 1);
      a_eu_flags = 4'h6;
      tick();
      check("hold issue_valid", a_issue_valid, 1'b1);
      check("hold number",      a_number,      8'hFE);
      check("hold theflag",     a_theflag,     4'h0);
    end
    a_eu_done  = 1'b0;
    a_eu_ready = 1'b1;
    a_eu_flags = 4'hA;
    tick();
    a_eu_ready = 1'b0;
    check("single theflag",  a_theflag,     4'hA);
    check("single in_ready", a_in_ready,    1'b1);
    check("single issue",    a_issue_valid, 1'b0);

    // Multi-cycle op 3; eu_done during the handoff cycle is ignored.
    a_instr    = 32'h3000_8421;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    a_eu_ready = 1'b1;
    a_eu_done  = 1'b1;
    a_eu_flags = 4'hF;
    tick();
    a_eu_ready = 1'b0;
    a_eu_done  = 1'b0;
    check("exec busy",    a_busy,        1'b1);
    check("exec issue",   a_issue_valid, 1'b0);
    check("exec theflag", a_theflag,     4'hA);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("exec busy hold", a_busy, 1'b1);
    end
    a_eu_done  = 1'b1;
    a_eu_flags = 4'h5;
    tick();
    a_eu_done  = 1'b0;
    check("done theflag",  a_theflag,  4'h5);
    check("done busy",     a_busy,     1'b0);
    check("done in_ready", a_in_ready, 1'b1);

    // Illegal op 15: one-cycle pulse, fields unchanged, stays idle.
    a_instr    = 32'hF123_4567;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check("ill pulse",    a_illegal,     1'b1);
    check("ill issue",    a_issue_valid, 1'b0);
    check("ill opcode",   a_opcode,      4'h3);
    check("ill in_ready", a_in_ready,    1'b1);
    tick();
    check("ill cleared",  a_illegal,     1'b0);

    // Throughput: eu_ready held high, a new word offered every cycle.
    acc        = 0;
    a_eu_ready = 1'b1;
    a_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_instr    = tp_tab[i];
      a_eu_flags = 4'(i);
      if (a_in_ready) acc++;
      tick();
    end
    a_in_valid = 1'b0;
    a_eu_ready = 1'b0;
    check("tput accepts", acc,       4);
    check("tput theflag", a_theflag, 4'h7);

    // Reset during EXEC, then a spurious eu_done.
    a_instr    = 32'h3ABC_1234;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    a_eu_ready = 1'b1;
    a_eu_flags = 4'h7;
    tick();
    a_eu_ready = 1'b0;
    check("abort pre busy", a_busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n      = 1'b1;
    a_eu_done  = 1'b1;
    a_eu_flags = 4'h9;
    tick();
    a_eu_done  = 1'b0;
    check("abort theflag",  a_theflag,  4'h0);
    check("abort busy",     a_busy,     1'b0);
    check("abort in_ready", a_in_ready, 1'b1);
    check("abort opcode",   a_opcode,   4'h0);

    // Wide instance: random words against a shift/mask field reference.
    for (int i = 0; i < 8; i++) begin
      logic [63:0] w;
      w = {32'($urandom), 32'($urandom)};
      b_instr = 40'(w);
      check("B in_ready", b_in_ready, 1'b1);
      b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      check("B opcode", b_opcode, (w >> 35) & 64'h1F);
      check("B addr1",  b_addr1,  w & 64'h3F);
      check("B addr2",  b_addr2,  (w >> 6) & 64'h3F);
      check("B addr3",  b_addr3,  (w >> 12) & 64'h3F);
      check("B number", b_number, (w >> 18) & 64'h3FF);
      check("B issue",  b_issue_valid, 1'b1);
      b_eu_ready = 1'b1;
      tick();
      b_eu_ready = 1'b0;
      check("B busy",   b_busy, 1'b0);
    end
    check("B illegal", b_illegal, 1'b0);
    check("B theflag", b_theflag, 4'h0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
